nn_argmax: RTL and testbench
============================

NN_ARGMAX -- requirements
Module: nn_argmax

Interface
REQ-001 SHALL have parameter M, default 4: number of layer outputs per frame, which is the element count of the upstream y vector; legal range M>=1.
REQ-002 SHALL have parameter T, default 16: signed data width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port s_valid, input, 1: upstream data valid.
REQ-006 SHALL have port s_ready, output, 1: block accepts data_in this cycle.
REQ-007 SHALL have port data_in, input, T, signed: one layer output per beat, in index order 0..M-1.
REQ-008 SHALL have port m_valid, output, 1: result valid.
REQ-009 SHALL have port m_ready, input, 1: downstream accepts the result.
REQ-010 SHALL have port idx_out, output, max(1,$clog2(M)): index of the maximum element.
REQ-011 SHALL have port max_out, output, T, signed: the maximum value; present only under ARGMAX_VALUE_OUT_EN.

Function
REQ-012 SHALL implement a 2-state FSM: COLLECT (s_ready=1, m_valid=0) and HOLD (s_ready=0, m_valid=1).
REQ-013 SHALL accept a beat only when s_valid&&s_ready; s_valid while in HOLD is ignored, and that data is not consumed.
REQ-014 SHALL keep a beat counter cnt of width $clog2(M+1), counting 0..M-1 accepted beats.
REQ-015 On beat cnt==0, SHALL load best_val=data_in and best_idx=0 unconditionally.
REQ-016 On beat cnt>0, SHALL replace best when data_in > best_val (signed, strict); on ties the lowest index is kept.
REQ-017 On beat cnt==M-1, SHALL apply the comparison of that last beat, wrap cnt to 0, and go to HOLD.
REQ-018 Latency: m_valid SHALL rise on the clock edge that accepts the M-th beat, and be visible the following cycle.
REQ-019 idx_out and max_out SHALL be registered and held stable while m_valid=1 and m_ready=0.
REQ-020 In HOLD with m_ready=1, SHALL return to COLLECT on the next edge; s_ready rises the cycle after the handshake, with no same-cycle overlap.
REQ-021 Steady-state throughput: 1 frame per M+1 cycles with both sides always ready.
REQ-022 Gaps (s_valid=0) within a frame SHALL stall cnt and best without loss.
REQ-023 For M=1, every accepted beat SHALL produce a result with idx_out=0.
REQ-024 Comparison SHALL use the full T-bit signed range: -32768 is less than any other value; no saturation is applied.

Reset
REQ-025 Asserting reset at any time, including mid-frame or in HOLD, SHALL force state=COLLECT, cnt=0, m_valid=0, idx_out=0, max_out=0 and best=0; any partial frame is discarded.
REQ-026 After reset deasserts, the first accepted beat SHALL be treated as index 0.

Configuration
REQ-027 Macro ARGMAX_VALUE_OUT_EN: when defined, the max_out port and its output register exist and carry best_val; when undefined, the port is absent, only idx_out is produced, and the FSM and timing are identical.

Structure
REQ-028 Package nn_pkg SHALL hold the shared data width constant (16), the typedef for signed T-bit data, and the FSM state enum typedef.
REQ-029 One sub-module, nn_argmax_cmp, is natural: a combinational signed strict-greater compare plus select, returning the updated best value and index.

Verification
REQ-030 M=4, input 10,50,30,20 with m_ready=1 -> idx_out=1, max_out=50, m_valid high for exactly 1 cycle, s_ready low for 1 cycle.
REQ-031 Tie: input 7,7,3,7 -> idx_out=0, max_out=7.
REQ-032 Signed: input -5,-2,-9,-32768 -> idx_out=1, max_out=-2.
REQ-033 Backpressure: m_ready=0 for 5 cycles after the result of 0,0,0,99 -> idx_out=3 held stable, s_ready=0 throughout, and s_valid beats are not consumed until the handshake completes.
REQ-034 Reset after 2 beats (1,2), then a frame of 4,3,2,1 -> idx_out=0, max_out=4; no result is emitted for the partial frame.
REQ-035 Random s_valid gaps over 1000 frames -> results match a reference-model argmax, and throughput equals M+1 cycles per frame when no gaps occur.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the argmax block: default data width, the signed
// data type and the collect/hold state encoding.
package nn_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage : nn_pkg

// File: rtl/nn_argmax_cmp.sv
// Running-best update for the argmax block: signed strict-greater compare of
// the incoming element against the current best, plus the select that
// returns the updated best value and index. On the first beat of a frame
// the incoming element is taken unconditionally.
module nn_argmax_cmp
    import nn_pkg::*;
#(
    parameter int T  = DATA_W,
    parameter int IW = 2
) (
    input  logic                i_first,
    input  logic signed [T-1:0] i_best_val,
    input  logic [IW-1:0]       i_best_idx,
    input  logic signed [T-1:0] i_new_val,
    input  logic [IW-1:0]       i_new_idx,
    output logic signed [T-1:0] o_best_val,
    output logic [IW-1:0]       o_best_idx
);

    // Strict '>' keeps the earlier (lower) index on ties
    always_comb begin
        o_best_val = i_best_val;
        o_best_idx = i_best_idx;
        if (i_first || (i_new_val > i_best_val)) begin
            o_best_val = i_new_val;
            o_best_idx = i_new_idx;
        end else begin
            o_best_val = i_best_val;
            o_best_idx = i_best_idx;
        end
    end

endmodule : nn_argmax_cmp

// File: rtl/nn_argmax.sv
// Streaming argmax over frames of M signed elements.
// Beats are collected one per s_valid&&s_ready; after the M-th beat the
// block holds the index (and optionally the value) of the maximum until the
// downstream handshake, then resumes collecting.
// Optional feature: define ARGMAX_VALUE_OUT_EN to add the max_out port.
module nn_argmax
    import nn_pkg::*;
#(
    parameter int M = 4,
    parameter int T = DATA_W,
    localparam int IW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [T-1:0] data_in,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [IW-1:0]       idx_out
`ifdef ARGMAX_VALUE_OUT_EN
    ,
    output logic signed [T-1:0] max_out
`endif
);

    localparam int CW = $clog2(M + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic signed [T-1:0] r_best_val;
    logic signed [T-1:0] w_best_val_nxt;
    logic [IW-1:0]       r_best_idx;
    logic [IW-1:0]       w_best_idx_nxt;
    logic [IW-1:0]       r_idx_out;
    logic                w_load_out;
    logic                w_accept;
    logic                w_first;
    logic                w_last;
    logic [IW-1:0]       w_beat_idx;
    logic signed [T-1:0] w_cmp_val;
    logic [IW-1:0]       w_cmp_idx;

    assign w_accept   = s_valid && (r_state == COLLECT);
    assign w_first    = (r_cnt == CW'(0));
    assign w_last     = (r_cnt == CW'(M - 1));
    assign w_beat_idx = IW'(r_cnt);

    nn_argmax_cmp #(
        .T  (T),
        .IW (IW)
    ) u_cmp (
        .i_first    (w_first),
        .i_best_val (r_best_val),
        .i_best_idx (r_best_idx),
        .i_new_val  (data_in),
        .i_new_idx  (w_beat_idx),
        .o_best_val (w_cmp_val),
        .o_best_idx (w_cmp_idx)
    );

    // Next-state, beat counter and running-best update
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_best_val_nxt = r_best_val;
        w_best_idx_nxt = r_best_idx;
        w_load_out     = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_accept) begin
                    w_best_val_nxt = w_cmp_val;
                    w_best_idx_nxt = w_cmp_idx;
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = HOLD;
                        w_load_out  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end else begin
                    w_state_nxt = COLLECT;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    w_state_nxt = COLLECT;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register, beat counter and running best; reset discards any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= COLLECT;
            r_cnt      <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_best_val <= w_best_val_nxt;
            r_best_idx <= w_best_idx_nxt;
        end
    end

    // Result index register, captured on the final beat and held through HOLD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx_out <= '0;
        end else if (w_load_out) begin
            r_idx_out <= w_cmp_idx;
        end
    end

`ifdef ARGMAX_VALUE_OUT_EN
    logic signed [T-1:0] r_max_out;

    // Result value register, captured alongside the index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_max_out <= '0;
        end else if (w_load_out) begin
            r_max_out <= w_cmp_val;
        end
    end

    assign max_out = r_max_out;
`endif

    assign s_ready = (r_state == COLLECT);
    assign m_valid = (r_state == HOLD);
    assign idx_out = r_idx_out;

endmodule : nn_argmax

// File: tb/tb_nn_argmax.sv
// Self-checking bench for nn_argmax (M=4, T=16). A scoreboard queue holds the
// expected argmax of each issued frame; a monitor pops and compares on every
// output handshake. Works with or without ARGMAX_VALUE_OUT_EN.
module tb_nn_argmax;

    localparam int M  = 4;
    localparam int T  = 16;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                s_valid;
    logic                s_ready;
    logic signed [T-1:0] data_in;
    logic                m_valid;
    logic                m_ready;
    logic [IW-1:0]       idx_out;
`ifdef ARGMAX_VALUE_OUT_EN
    logic signed [T-1:0] max_out;
`endif

    typedef struct {
        int idx;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   fr[M];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    bit   rand_rdy = 1'b0;

    nn_argmax #(.M(M), .T(T)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .data_in (data_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .idx_out (idx_out)
`ifdef ARGMAX_VALUE_OUT_EN
        ,
        .max_out (max_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance to just after the next rising edge; optionally randomise m_ready
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle();
        int r;
        r       = $urandom;
        s_valid = 1'b0;
        data_in = r[T-1:0];
        step();
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded)
    task automatic send_beat(input int v);
        bit acc;
        int tmo;
        acc     = 1'b0;
        tmo     = 0;
        s_valid = 1'b1;
        data_in = v[T-1:0];
        while (!acc && tmo < 1000) begin
            @(negedge clk);
            acc = s_ready;
            step();
            tmo++;
        end
        if (!acc) check("beat_accept_timeout", 0, 1);
    endtask

    // Reference argmax: first position holding the largest value
    task automatic send_frame(input int gap_max);
        int   best;
        exp_t e;
        best = 0;
        for (int i = 1; i < M; i++) begin
            if (fr[i] > fr[best]) best = i;
        end
        e.idx = best;
        e.val = fr[best];
        exp_q.push_back(e);
        for (int i = 0; i < M; i++) begin
            repeat ($urandom_range(0, gap_max)) idle();
            send_beat(fr[i]);
        end
        s_valid = 1'b0;
    endtask

    // Monitor: compare each presented result at handshake time
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && m_valid && m_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_result: got idx %0d, expected no result", idx_out);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_idx", int'(idx_out), e.idx);
`ifdef ARGMAX_VALUE_OUT_EN
                    check("sb_max", int'(max_out), e.val);
`endif
                end
            end
        end
    end

    initial begin
        int mode;
        int r;
        int pick[4];
        pick[0] = -32768; pick[1] = 32767; pick[2] = 0; pick[3] = -1;

        reset   = 1'b1;
        s_valid = 1'b0;
        data_in = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_idx", int'(idx_out), 0);
`ifdef ARGMAX_VALUE_OUT_EN
        check("rst_max", int'(max_out), 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic frame: latency and one-cycle result pulse
        m_ready = 1'b1;
        fr = '{10, 50, 30, 20};
        send_frame(0);
        @(negedge clk);
        check("lat_m_valid", int'(m_valid), 1);
        check("lat_s_ready", int'(s_ready), 0);
        step();
        @(negedge clk);
        check("pulse_m_valid_low", int'(m_valid), 0);
        check("pulse_s_ready_high", int'(s_ready), 1);
        step();

        // Tie, signed extremes, and back-to-back throughput
        hs_cyc.delete();
        fr = '{7, 7, 3, 7};
        send_frame(0);
        fr = '{-5, -2, -9, -32768};
        send_frame(0);
        fr = '{1, 2, 3, 4};
        send_frame(0);
        repeat (3) step();
        check("tput_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check("tput_gap0", hs_cyc[1] - hs_cyc[0], M + 1);
            check("tput_gap1", hs_cyc[2] - hs_cyc[1], M + 1);
        end

        // Backpressure: result held, pending beat not consumed
        m_ready = 1'b0;
        fr = '{0, 0, 0, 99};
        send_frame(0);
        s_valid = 1'b1;
        data_in = 16'sd5;
        repeat (5) begin
            @(negedge clk);
            check("bp_m_valid", int'(m_valid), 1);
            check("bp_s_ready", int'(s_ready), 0);
            check("bp_idx_hold", int'(idx_out), 3);
`ifdef ARGMAX_VALUE_OUT_EN
            check("bp_max_hold", int'(max_out), 99);
`endif
            step();
        end
        m_ready = 1'b1;
        fr = '{5, 1, 2, 3};
        send_frame(0);
        repeat (2) step();

        // Reset mid-frame discards the partial frame
        send_beat(1);
        send_beat(2);
        s_valid = 1'b0;
        reset   = 1'b1;
        step();
        @(negedge clk);
        check("midrst_s_ready", int'(s_ready), 1);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_idx", int'(idx_out), 0);
        step();
        reset = 1'b0;
        fr = '{4, 3, 2, 1};
        send_frame(0);
        repeat (2) step();

        // Random frames with input gaps and random downstream stalls
        rand_rdy = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < M; i++) begin
                if (mode == 0) begin
                    fr[i] = int'($urandom_range(0, 65535)) - 32768;
                end else if (mode == 1) begin
                    fr[i] = int'($urandom_range(0, 4)) - 2;
                end else begin
                    r     = $urandom_range(0, 3);
                    fr[i] = pick[r];
                end
            end
            send_frame($urandom_range(0, 2));
        end

        // Drain outstanding results
        rand_rdy = 1'b0;
        m_ready  = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
        repeat (2) step();
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_nn_argmax
